// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit controller:
//   state_t        - controller FSM states
//   SEL_*          - TX output mux select codes
//   PAR_EVEN/ODD   - PAR_TYP encodings
//   parity_of()    - parity bit for a data word (up to 9 bits) and parity type
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;  // also the idle-high level
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Narrower words are zero-extended by the caller, which leaves the XOR
    // reduction unchanged.
    function automatic logic parity_of(input logic [8:0] d, input logic typ);
        return (typ == PAR_EVEN) ? (^d) : ~(^d);
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Load/shift register plus bit counter for the data slots of a frame.
//   clk, rst_n  - clock, asynchronous active-low reset
//   ser_load    - capture load_data and clear the bit counter
//   ser_en      - one data bit per cycle: shift right, advance counter
//   load_data   - parallel word to serialize
//   ser_data    - current data bit (LSB of the shift register)
//   ser_done    - high during the last data bit
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ser_load,
    input  logic                  ser_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ser_data,
    output logic                  ser_done
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (ser_load) begin
            shreg <= load_data;
            cnt   <= '0;
        end else if (ser_en) begin
            // Zeros shift in, so ser_data settles at 0 once a frame is sent.
            shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
            cnt   <= ser_done ? '0 : cnt + CW'(1);
        end
    end

    assign ser_data = shreg[0];
    assign ser_done = ser_en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// Sequences the external 4:1 TX mux through start, data, optional parity and
// stop slots, one slot per CLK cycle.
//   CLK, RST    - TX bit clock, asynchronous active-low reset
//   P_DATA      - parallel word, captured when a frame is accepted
//   Data_Valid  - transmit request
//   PAR_EN      - insert a parity slot (captured with P_DATA)
//   PAR_TYP     - 0 even / 1 odd parity (captured with P_DATA)
//   mux_sel     - TX mux select (registered)
//   ser_data    - current data bit for the mux data input
//   PAR_bit     - parity bit for the mux parity input (registered)
//   busy        - high for every cycle of a frame (registered)
//   dbg_state   - current FSM state, for observation only
//
// Handshake: a frame is accepted on a rising CLK edge where Data_Valid=1 and
// the FSM is IDLE (busy=0 in that cycle). busy acts as the inverse of ready;
// requests seen while busy=1 are dropped, not queued, so a source must hold
// Data_Valid until it observes busy rise.
// -----------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  PAR_bit,
    output logic                  busy,
    output logic [2:0]            dbg_state
);

    state_t state;
    logic   par_en_q;
    logic   ser_load;
    logic   ser_en;
    logic   ser_done;

    assign ser_load  = (state == IDLE) && Data_Valid;
    assign ser_en    = (state == DATA);
    assign dbg_state = state;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk       (CLK),
        .rst_n     (RST),
        .ser_load  (ser_load),
        .ser_en    (ser_en),
        .load_data (P_DATA),
        .ser_data  (ser_data),
        .ser_done  (ser_done)
    );

    // mux_sel and busy are loaded together with the next state, so they always
    // match the slot being entered and never show an intermediate code.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            mux_sel  <= SEL_STOP;
            busy     <= 1'b0;
            PAR_bit  <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Data_Valid) begin
                        state    <= START;
                        mux_sel  <= SEL_START;
                        busy     <= 1'b1;
                        par_en_q <= PAR_EN;
                        // Computed from the word being loaded, so it is ready
                        // from the START cycle and held until the next accept.
                        PAR_bit  <= parity_of(9'(P_DATA), PAR_TYP);
                    end
                end
                START: begin
                    state   <= DATA;
                    mux_sel <= SEL_DATA;
                end
                DATA: begin
                    if (ser_done) begin
                        if (par_en_q) begin
                            state   <= PARITY;
                            mux_sel <= SEL_PAR;
                        end else begin
                            state   <= STOP;
                            mux_sel <= SEL_STOP;
                        end
                    end
                end
                PARITY: begin
                    state   <= STOP;
                    mux_sel <= SEL_STOP;
                end
                STOP: begin
                    state   <= IDLE;
                    mux_sel <= SEL_STOP;
                    busy    <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    mux_sel <= SEL_STOP;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Directed bench for uart_tx_ctrl. Inputs change and outputs are sampled on the
// falling CLK edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;
    import uart_tx_pkg::*;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [1:0]    mux_sel;
    logic          ser_data;
    logic          PAR_bit;
    logic          busy;
    logic [2:0]    dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard entry: {busy, mux_sel[1:0], check_ser_data, ser_data}
    logic [4:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    uart_tx_ctrl #(
        .DATA_WIDTH (DW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .PAR_bit    (PAR_bit),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic dv, input logic [DW-1:0] d, input logic pe, input logic pt);
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
    endtask

    // Called at a falling edge in IDLE with the request already driven; the
    // next rising edge accepts. In the START cycle the request lines are
    // replaced with after_dv / after_data to show the frame ignores them.
    task automatic expect_frame(input string tag, input logic [DW-1:0] data,
                                input logic pe, input logic exp_par,
                                input logic after_dv, input logic [DW-1:0] after_data);
        logic [4:0] e;
        exp_q.push_back({1'b1, SEL_START, 2'b00});
        for (int i = 0; i < DW; i++) exp_q.push_back({1'b1, SEL_DATA, 1'b1, data[i]});
        if (pe) exp_q.push_back({1'b1, SEL_PAR, 2'b00});
        exp_q.push_back({1'b1, SEL_STOP, 2'b00});
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                Data_Valid = after_dv;
                P_DATA     = after_data;
            end
            e = exp_q.pop_front();
            chk($sformatf("%s busy[%0d]", tag, k), 32'(busy), 32'(e[4]));
            chk($sformatf("%s mux_sel[%0d]", tag, k), 32'(mux_sel), 32'(e[3:2]));
            chk($sformatf("%s par_bit[%0d]", tag, k), 32'(PAR_bit), 32'(exp_par));
            if (e[1]) chk($sformatf("%s ser_data[%0d]", tag, k), 32'(ser_data), 32'(e[0]));
        end
    endtask

    task automatic expect_idle(input string tag);
        @(negedge CLK);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " idle mux_sel"}, 32'(mux_sel), 32'(SEL_STOP));
        chk({tag, " idle state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b0;
        drive(1'b0, 8'h00, 1'b0, PAR_EVEN);
        repeat (3) @(negedge CLK);
        RST = 1'b1;

        // Reset / idle values.
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("rst busy[%0d]", i), 32'(busy), 32'd0);
            chk($sformatf("rst mux_sel[%0d]", i), 32'(mux_sel), 32'(SEL_STOP));
            chk($sformatf("rst ser_data[%0d]", i), 32'(ser_data), 32'd0);
            chk($sformatf("rst par_bit[%0d]", i), 32'(PAR_bit), 32'd0);
            chk($sformatf("rst state[%0d]", i), 32'(dbg_state), 32'(IDLE));
        end

        // 0xA5, no parity: 10-cycle frame.
        drive(1'b1, 8'hA5, 1'b0, PAR_EVEN);
        expect_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5);
        expect_idle("a5_nopar");

        // 0xA5 has four ones: even -> 0, odd -> 1.
        drive(1'b1, 8'hA5, 1'b1, PAR_EVEN);
        expect_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5);
        expect_idle("a5_even");

        drive(1'b1, 8'hA5, 1'b1, PAR_ODD);
        expect_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5);
        expect_idle("a5_odd");

        // 0x00 odd parity -> 1; P_DATA switches to 0xFF after acceptance.
        drive(1'b1, 8'h00, 1'b1, PAR_ODD);
        expect_frame("zero_odd", 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF);
        expect_idle("zero_odd");

        // Data_Valid held high: 0x3C then 0xC3, exactly one idle cycle between.
        drive(1'b1, 8'h3C, 1'b0, PAR_EVEN);
        expect_frame("hold1", 8'h3C, 1'b0, 1'b0, 1'b1, 8'hC3);
        expect_idle("hold_gap");
        expect_frame("hold2", 8'hC3, 1'b0, 1'b0, 1'b0, 8'hC3);
        expect_idle("hold2");

        // Asynchronous reset during data bit 4 of 0x5A (odd parity -> 1).
        drive(1'b1, 8'h5A, 1'b1, PAR_ODD);
        @(negedge CLK);
        Data_Valid = 1'b0;
        chk("abort start mux_sel", 32'(mux_sel), 32'(SEL_START));
        repeat (5) @(negedge CLK);
        chk("abort bit4 mux_sel", 32'(mux_sel), 32'(SEL_DATA));
        chk("abort bit4 ser_data", 32'(ser_data), 32'd1);
        chk("abort bit4 par_bit", 32'(PAR_bit), 32'd1);
        #1 RST = 1'b0;
        #1;
        chk("abort async mux_sel", 32'(mux_sel), 32'(SEL_STOP));
        chk("abort async busy", 32'(busy), 32'd0);
        chk("abort async ser_data", 32'(ser_data), 32'd0);
        chk("abort async par_bit", 32'(PAR_bit), 32'd0);
        chk("abort async state", 32'(dbg_state), 32'(IDLE));
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        expect_idle("post_rst1");
        expect_idle("post_rst2");

        // Complete frame after reset release: 0x5A even parity -> 0.
        drive(1'b1, 8'h5A, 1'b1, PAR_EVEN);
        expect_frame("post_rst", 8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A);
        expect_idle("post_rst");

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
